// File: rtl/aes128_enc_ctrl_if.sv
// Host-side handshake bundle for the iterative AES-128 encryptor.
interface aes128_enc_ctrl_if;
  logic         in_valid;
  logic         in_ready;
  logic [127:0] in_data;
  logic [127:0] in_key;
  logic         out_valid;
  logic         out_ready;
  logic [127:0] out_data;
  logic         busy;
  logic [3:0]   round_o;

  modport slave (
    input  in_valid, in_data, in_key, out_ready,
    output in_ready, out_valid, out_data, busy, round_o
  );

  modport master (
    output in_valid, in_data, in_key, out_ready,
    input  in_ready, out_valid, out_data, busy, round_o
  );
endinterface

// File: rtl/aes128_enc_ctrl.sv
// Iterative AES-128 encryptor: one round per clock, keys expanded on the fly.
// Byte i of a block (FIPS byte order) sits in bits [127-8i -: 8]; column c is
// bytes 4c..4c+3, so column c of the key is key word w[c].
module aes128_enc_ctrl (
  input  logic             clk,
  input  logic             rst_n,
  aes128_enc_ctrl_if.slave io
);

  typedef enum logic [1:0] {IDLE, ROUND, DONE} st_e;
  // element [15-i] holds FIPS byte i
  typedef logic [15:0][7:0] blk_t;

  function automatic logic [7:0] xtime(input logic [7:0] a);
    return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p, x, bb;
    p  = '0;
    x  = a;
    bb = b;
    for (int i = 0; i < 8; i++) begin
      if (bb[0]) p = p ^ x;
      x  = xtime(x);
      bb = bb >> 1;
    end
    return p;
  endfunction

  // S-box as GF(2^8) inverse (x^254, with 0 -> 0) followed by the affine map
  function automatic logic [7:0] sbox(input logic [7:0] x);
    logic [7:0] x2, x3, x6, x12, x15, x30, x60, x120, x240, x252, v;
    x2   = gmul(x, x);
    x3   = gmul(x2, x);
    x6   = gmul(x3, x3);
    x12  = gmul(x6, x6);
    x15  = gmul(x12, x3);
    x30  = gmul(x15, x15);
    x60  = gmul(x30, x30);
    x120 = gmul(x60, x60);
    x240 = gmul(x120, x120);
    x252 = gmul(x240, x12);
    v    = gmul(x252, x2);
    return v ^ {v[6:0], v[7]} ^ {v[5:0], v[7:6]} ^ {v[4:0], v[7:5]}
             ^ {v[3:0], v[7:4]} ^ 8'h63;
  endfunction

  function automatic logic [31:0] sub_word(input logic [31:0] w);
    return {sbox(w[31:24]), sbox(w[23:16]), sbox(w[15:8]), sbox(w[7:0])};
  endfunction

  function automatic logic [31:0] mix_col(input logic [31:0] a);
    logic [7:0] a0, a1, a2, a3;
    {a0, a1, a2, a3} = a;
    return {xtime(a0) ^ xtime(a1) ^ a1 ^ a2 ^ a3,
            a0 ^ xtime(a1) ^ xtime(a2) ^ a2 ^ a3,
            a0 ^ a1 ^ xtime(a2) ^ xtime(a3) ^ a3,
            xtime(a0) ^ a0 ^ a1 ^ a2 ^ xtime(a3)};
  endfunction

  function automatic logic [7:0] rcon(input logic [3:0] r);
    case (r)
      4'd1:    return 8'h01;
      4'd2:    return 8'h02;
      4'd3:    return 8'h04;
      4'd4:    return 8'h08;
      4'd5:    return 8'h10;
      4'd6:    return 8'h20;
      4'd7:    return 8'h40;
      4'd8:    return 8'h80;
      4'd9:    return 8'h1b;
      4'd10:   return 8'h36;
      default: return 8'h00;
    endcase
  endfunction

  function automatic logic [127:0] expand(input logic [127:0] rk, input logic [7:0] rc);
    logic [31:0] t, w0, w1, w2, w3;
    t  = sub_word({rk[23:0], rk[31:24]}) ^ {rc, 24'h0};
    w0 = rk[127:96] ^ t;
    w1 = rk[95:64]  ^ w0;
    w2 = rk[63:32]  ^ w1;
    w3 = rk[31:0]   ^ w2;
    return {w0, w1, w2, w3};
  endfunction

  st_e          st_q, st_d;
  blk_t         state_q;
  logic [127:0] key_q;
  logic [3:0]   round_q;
  logic         out_valid_q, busy_q;
  logic         accept;

  blk_t         sb_out, sr_out, mc_out;
  logic [127:0] rk_nxt, rnd_out;

  // SubBytes, one S-box per byte lane
  for (genvar i = 0; i < 16; i++) begin : g_sb
    assign sb_out[i] = sbox(state_q[i]);
  end

  // ShiftRows: row r of column c takes row r of column (c+r)%4
  assign sr_out = {sb_out[15], sb_out[10], sb_out[5],  sb_out[0],
                   sb_out[11], sb_out[6],  sb_out[1],  sb_out[12],
                   sb_out[7],  sb_out[2],  sb_out[13], sb_out[8],
                   sb_out[3],  sb_out[14], sb_out[9],  sb_out[4]};

  // MixColumns, one mixer per column lane
  for (genvar c = 0; c < 4; c++) begin : g_mc
    assign mc_out[15-4*c -: 4] = mix_col(sr_out[15-4*c -: 4]);
  end

  // next round key and round result; the last round skips MixColumns
  always_comb begin
    rk_nxt  = expand(key_q, rcon(round_q));
    rnd_out = ((round_q == 4'd10) ? sr_out : mc_out) ^ rk_nxt;
  end

  // FSM state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) st_q <= IDLE;
    else        st_q <= st_d;
  end

  // FSM next state and accept strobe
  always_comb begin
    st_d   = st_q;
    accept = 1'b0;
    case (st_q)
      IDLE: if (io.in_valid) begin
        accept = 1'b1;
        st_d   = ROUND;
      end
      ROUND:   if (round_q == 4'd10) st_d = DONE;
      DONE:    if (io.out_ready) st_d = IDLE;
      default: st_d = IDLE;
    endcase
  end

  // block state, round key, round counter and registered status outputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= '0;
      key_q       <= '0;
      round_q     <= '0;
      out_valid_q <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      out_valid_q <= (st_d == DONE);
      busy_q      <= (st_d != IDLE);
      case (st_q)
        IDLE: if (accept) begin
          state_q <= io.in_data ^ io.in_key;
          key_q   <= io.in_key;
          round_q <= 4'd1;
        end
        ROUND: begin
          state_q <= rnd_out;
          key_q   <= rk_nxt;
          if (round_q != 4'd10) round_q <= round_q + 4'd1;
        end
        DONE:    if (io.out_ready) round_q <= 4'd0;
        default: ;
      endcase
    end
  end

  assign io.in_ready  = (st_q == IDLE);
  assign io.out_valid = out_valid_q;
  assign io.out_data  = state_q;
  assign io.busy      = busy_q;
  assign io.round_o   = round_q;

endmodule

// File: tb/tb_aes128_enc_ctrl.sv
// Self-checking bench for aes128_enc_ctrl: FIPS vectors, stalls, back-to-back,
// input corruption, mid-round reset and random blocks against a byte-level model.
module tb_aes128_enc_ctrl;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  aes128_enc_ctrl_if io();

  aes128_enc_ctrl dut (.clk(clk), .rst_n(rst_n), .io(io));

  always #5 clk = ~clk;

  int n_chk = 0;
  int n_fail = 0;
  int cyc = 0;
  int acc_t[$];
  logic [7:0] sb [256];

  // cycle counter and accept-edge log
  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (rst_n && io.in_valid && io.in_ready) acc_t.push_back(cyc);
  end

  initial begin
    #400000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1);
  end

  task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // GF(2^8) multiply: carry-less product then long division by 0x11b
  function automatic logic [7:0] gm(input logic [7:0] a, input logic [7:0] b);
    logic [14:0] p;
    p = '0;
    for (int i = 0; i < 8; i++) if (b[i]) p = p ^ (15'(a) << i);
    for (int i = 14; i >= 8; i--) if (p[i]) p = p ^ (15'h11b << (i - 8));
    return p[7:0];
  endfunction

  // S-box from brute-force inverse and the bitwise affine formula
  function automatic void build_sbox();
    logic [7:0] inv, s, c;
    c = 8'h63;
    for (int x = 0; x < 256; x++) begin
      inv = 8'h00;
      for (int y = 1; y < 256; y++) if (gm(8'(x), 8'(y)) == 8'h01) inv = 8'(y);
      for (int i = 0; i < 8; i++)
        s[i] = inv[i] ^ inv[(i+4)%8] ^ inv[(i+5)%8] ^ inv[(i+6)%8] ^ inv[(i+7)%8] ^ c[i];
      sb[x] = s;
    end
  endfunction

  // state after nr rounds of AES-128 (nr=10 gives the ciphertext)
  function automatic logic [127:0] aes_ref(input logic [127:0] pt, input logic [127:0] key, input int nr);
    logic [7:0]  s [16];
    logic [7:0]  t [16];
    logic [31:0] w [44];
    logic [31:0] tmp;
    logic [7:0]  rc;
    logic [127:0] o;
    for (int i = 0; i < 4; i++) w[i] = key[127-32*i -: 32];
    rc = 8'h01;
    for (int i = 4; i < 44; i++) begin
      tmp = w[i-1];
      if (i % 4 == 0) begin
        tmp = {sb[tmp[23:16]], sb[tmp[15:8]], sb[tmp[7:0]], sb[tmp[31:24]]} ^ {rc, 24'h0};
        rc  = gm(rc, 8'h02);
      end
      w[i] = w[i-4] ^ tmp;
    end
    for (int i = 0; i < 16; i++) s[i] = pt[127-8*i -: 8] ^ key[127-8*i -: 8];
    for (int r = 1; r <= nr; r++) begin
      for (int i = 0; i < 16; i++) t[i] = sb[s[i]];
      for (int c = 0; c < 4; c++)
        for (int rr = 0; rr < 4; rr++) s[4*c+rr] = t[4*((c+rr)%4)+rr];
      if (r < 10) begin
        for (int c = 0; c < 4; c++)
          for (int rr = 0; rr < 4; rr++)
            t[4*c+rr] = gm(8'h02, s[4*c+rr]) ^ gm(8'h03, s[4*c+(rr+1)%4])
                      ^ s[4*c+(rr+2)%4] ^ s[4*c+(rr+3)%4];
        for (int i = 0; i < 16; i++) s[i] = t[i];
      end
      for (int i = 0; i < 16; i++) s[i] = s[i] ^ w[4*r + i/4][31-8*(i%4) -: 8];
    end
    for (int i = 0; i < 16; i++) o[127-8*i -: 8] = s[i];
    return o;
  endfunction

  function automatic logic [127:0] rnd128();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // offer a block and return one sample after its accept edge
  task automatic send(input logic [127:0] pt, input logic [127:0] k);
    int n;
    n = 0;
    io.in_data  = pt;
    io.in_key   = k;
    io.in_valid = 1'b1;
    while (!io.in_ready && n < 50) begin
      step();
      n++;
    end
    if (!io.in_ready) chk("accept_to", 128'(io.in_ready), 128'd1);
    step();
    io.in_valid = 1'b0;
  endtask

  task automatic wait_out(output int lat);
    lat = 0;
    while (!io.out_valid && lat < 50) begin
      step();
      lat++;
    end
    chk("out_valid_seen", 128'(io.out_valid), 128'd1);
  endtask

  // full encryption with immediate drain
  task automatic enc(input string tag, input logic [127:0] pt, input logic [127:0] k, input logic [127:0] exp);
    int lat;
    io.out_ready = 1'b1;
    send(pt, k);
    wait_out(lat);
    chk({tag, "_lat"}, 128'(lat), 128'd10);
    chk({tag, "_ct"}, io.out_data, exp);
    step();
    chk({tag, "_idle"}, 128'(io.in_ready), 128'd1);
    chk({tag, "_ov_lo"}, 128'(io.out_valid), 128'd0);
  endtask

  localparam logic [127:0] C1_KEY = 128'h000102030405060708090a0b0c0d0e0f;
  localparam logic [127:0] C1_PT  = 128'h00112233445566778899aabbccddeeff;
  localparam logic [127:0] C1_CT  = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
  localparam logic [127:0] B_KEY  = 128'h2b7e151628aed2a6abf7158809cf4f3c;
  localparam logic [127:0] B_PT   = 128'h3243f6a8885a308d313198a2e0370734;
  localparam logic [127:0] B_CT   = 128'h3925841d02dc09fbdc118597196a0b32;
  localparam logic [127:0] B_R1   = 128'ha49c7ff2689f352b6b5bea43026a5049;

  initial begin
    logic [127:0] p1, k1, p2, k2, held, e1;
    int lat, n, dly;
    io.in_valid  = 1'b0;
    io.in_data   = '0;
    io.in_key    = '0;
    io.out_ready = 1'b0;
    build_sbox();
    repeat (3) @(posedge clk);
    #1;
    // reset state
    chk("rst_in_ready", 128'(io.in_ready), 128'd1);
    chk("rst_out_valid", 128'(io.out_valid), 128'd0);
    chk("rst_busy", 128'(io.busy), 128'd0);
    chk("rst_round", 128'(io.round_o), 128'd0);
    chk("rst_out_data", io.out_data, 128'd0);
    rst_n = 1'b1;
    step();

    // FIPS-197 C.1
    enc("c1", C1_PT, C1_KEY, C1_CT);

    // FIPS-197 B with round trace, then 20-cycle stall
    io.out_ready = 1'b0;
    send(B_PT, B_KEY);
    for (int k = 1; k <= 10; k++) begin
      chk($sformatf("b_round%0d", k), 128'(io.round_o), 128'(k));
      chk($sformatf("b_busy%0d", k), 128'(io.busy), 128'd1);
      if (k == 2) chk("b_state_r1", io.out_data, B_R1);
      step();
    end
    chk("b_out_valid", 128'(io.out_valid), 128'd1);
    chk("b_ct", io.out_data, B_CT);
    held = io.out_data;
    for (int i = 0; i < 20; i++) begin
      io.in_valid = 1'($urandom_range(0, 1));
      io.in_data  = rnd128();
      io.in_key   = rnd128();
      step();
      chk("stall_ov", 128'(io.out_valid), 128'd1);
      chk("stall_data", io.out_data, held);
      chk("stall_in_ready", 128'(io.in_ready), 128'd0);
      chk("stall_round", 128'(io.round_o), 128'd10);
    end
    io.in_valid  = 1'b0;
    io.out_ready = 1'b1;
    step();
    chk("rel_in_ready", 128'(io.in_ready), 128'd1);
    chk("rel_ov", 128'(io.out_valid), 128'd0);
    chk("rel_busy", 128'(io.busy), 128'd0);
    chk("rel_round", 128'(io.round_o), 128'd0);
    chk("rel_data_kept", io.out_data, B_CT);

    // back-to-back with in_valid and out_ready held high
    p1 = rnd128(); k1 = rnd128(); p2 = rnd128(); k2 = rnd128();
    acc_t.delete();
    io.out_ready = 1'b1;
    io.in_data   = p1;
    io.in_key    = k1;
    io.in_valid  = 1'b1;
    n = 0;
    while (acc_t.size() == 0 && n < 50) begin step(); n++; end
    chk("b2b_acc1", 128'(acc_t.size()), 128'd1);
    io.in_data = p2;
    io.in_key  = k2;
    wait_out(lat);
    chk("b2b_lat1", 128'(lat), 128'd10);
    chk("b2b_ct1", io.out_data, aes_ref(p1, k1, 10));
    n = 0;
    while (acc_t.size() < 2 && n < 50) begin step(); n++; end
    io.in_valid = 1'b0;
    chk("b2b_acc2", 128'(acc_t.size()), 128'd2);
    if (acc_t.size() >= 2) chk("b2b_gap", 128'(acc_t[1] - acc_t[0]), 128'd12);
    wait_out(lat);
    chk("b2b_ct2", io.out_data, aes_ref(p2, k2, 10));
    step();

    // inputs churn every cycle after accept
    p1 = rnd128(); k1 = rnd128();
    io.out_ready = 1'b0;
    send(p1, k1);
    n = 0;
    while (!io.out_valid && n < 50) begin
      io.in_valid = 1'($urandom_range(0, 1));
      io.in_data  = rnd128();
      io.in_key   = rnd128();
      step();
      n++;
    end
    chk("corrupt_lat", 128'(n), 128'd10);
    chk("corrupt_ct", io.out_data, aes_ref(p1, k1, 10));
    io.in_valid  = 1'b0;
    io.out_ready = 1'b1;
    step();

    // reset in the middle of a block
    send(C1_PT, C1_KEY);
    repeat (5) step();
    chk("pre_rst_busy", 128'(io.busy), 128'd1);
    rst_n = 1'b0;
    #1;
    chk("mid_rst_ov", 128'(io.out_valid), 128'd0);
    chk("mid_rst_busy", 128'(io.busy), 128'd0);
    chk("mid_rst_round", 128'(io.round_o), 128'd0);
    chk("mid_rst_in_ready", 128'(io.in_ready), 128'd1);
    chk("mid_rst_data", io.out_data, 128'd0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    for (int i = 0; i < 12; i++) begin
      step();
      chk("post_rst_no_ov", 128'(io.out_valid), 128'd0);
    end
    enc("c1_again", C1_PT, C1_KEY, C1_CT);

    // random blocks with random drain delay
    for (int it = 0; it < 12; it++) begin
      p1 = rnd128(); k1 = rnd128();
      e1 = aes_ref(p1, k1, 10);
      io.out_ready = 1'b0;
      send(p1, k1);
      wait_out(lat);
      chk("rnd_lat", 128'(lat), 128'd10);
      chk("rnd_ct", io.out_data, e1);
      dly = $urandom_range(0, 3);
      for (int d = 0; d < dly; d++) begin
        step();
        chk("rnd_hold", io.out_data, e1);
      end
      io.out_ready = 1'b1;
      step();
      chk("rnd_idle", 128'(io.in_ready), 128'd1);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
